// File: rtl/pixel_write_sink.sv
// pixel_write_sink
//   Queues trace pixel writes and shares one single-port pixel memory between
//   the VGA scan-out (reads), a full-frame clear sweep and the queued writes.
//   Port priority each cycle: scan read > clear sweep > queued write > idle.
//
// Ports
//   VGA_CTRL_CLK                 sole clock, rising edge
//   reset                        asynchronous, active-low
//   write_xCoord/yCoord, w_en,   trace write request, one pixel per w_en cycle
//   disp_bit
//   clear_req                    one-cycle pulse, starts (or restarts) a clear sweep
//   display_xCoord/yCoord        current scan position from the VGA controller
//   mem_addr/mem_wdata/mem_we    registered memory port
//   mem_rdata                    memory read data, one cycle after the read address
//   pixel_color                  registered scan colour, two cycles after the scan position
//   fifo_full, clear_busy        status
//   drop_count                   saturating count of discarded requests
module pixel_write_sink #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned vga_width  = 640,
  parameter int unsigned vga_height = 480
) (
  input  logic        VGA_CTRL_CLK,
  input  logic        reset,
  input  logic [9:0]  write_xCoord,
  input  logic [8:0]  write_yCoord,
  input  logic        w_en,
  input  logic [1:0]  disp_bit,
  input  logic        clear_req,
  input  logic [9:0]  display_xCoord,
  input  logic [8:0]  display_yCoord,
  output logic [18:0] mem_addr,
  output logic [1:0]  mem_wdata,
  output logic        mem_we,
  input  logic [1:0]  mem_rdata,
  output logic [1:0]  pixel_color,
  output logic        fifo_full,
  output logic        clear_busy,
  output logic [15:0] drop_count
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  X_LIM     = 10'(vga_width);
  localparam logic [8:0]  Y_LIM     = 9'(vga_height);
  localparam logic [18:0] W_VEC     = 19'(vga_width);
  localparam logic [18:0] LAST_ADDR = 19'(vga_width * vga_height - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  // Port arbiter selections
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_READ  = 2'd1;
  localparam logic [1:0] ARB_CLEAR = 2'd2;
  localparam logic [1:0] ARB_WRITE = 2'd3;

  // y*vga_width + x as a sum of shifted copies of y, one per set bit of the width
  function automatic logic [18:0] f_addr(input logic [9:0] x, input logic [8:0] y);
    logic [18:0] acc;
    acc = {9'd0, x};
    for (int i = 0; i < 19; i++) begin
      if (W_VEC[i]) acc = acc + (19'(y) << i);
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [20:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          r_last_vld;
  logic [18:0]   r_last_addr;
  logic [1:0]    r_last_data;

  logic          r_clr_busy;
  logic [18:0]   r_clr_cnt;

  logic [18:0]   r_mem_addr;
  logic [1:0]    r_mem_wdata;
  logic          r_mem_we;
  logic          r_rd_vis;
  logic [1:0]    r_pix;
  logic [15:0]   r_drop;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic          w_full;
  logic          w_empty;
  logic          w_disp_vis;
  logic [18:0]   w_disp_addr;
  logic [18:0]   w_wr_addr;
  logic          w_wr_in_range;
  logic          w_wr_dup;
  logic [1:0]    w_sel;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [20:0]   w_head;

  assign w_full        = (r_count == DEPTH_CNT);
  assign w_empty       = (r_count == '0);
  assign w_disp_vis    = (display_xCoord < X_LIM) && (display_yCoord < Y_LIM);
  assign w_disp_addr   = f_addr(display_xCoord, display_yCoord);
  assign w_wr_addr     = f_addr(write_xCoord, write_yCoord);
  assign w_wr_in_range = (write_xCoord < X_LIM) && (write_yCoord < Y_LIM);
  assign w_wr_dup      = r_last_vld && (r_last_addr == w_wr_addr) && (r_last_data == disp_bit);
  assign w_head        = r_fifo[r_rptr];

  always_comb begin
    w_sel = ARB_IDLE;
    if (w_disp_vis) begin
      w_sel = ARB_READ;
    end else if (r_clr_busy) begin
      w_sel = ARB_CLEAR;
    end else if (!w_empty && !clear_req) begin
      // A clear request flushes the queue this cycle, so its head is not written.
      w_sel = ARB_WRITE;
    end
  end

  assign w_pop = (w_sel == ARB_WRITE);

  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push = w_en && w_wr_in_range && !w_wr_dup && !clear_req && (!w_full || w_pop);

  // Duplicates and requests flushed by clear_req are discarded without counting.
  assign w_drop = w_en && (!w_wr_in_range ||
                           (!clear_req && !w_wr_dup && w_full && !w_pop));

  // ---------------------------------------------------------------------------
  // Write queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge VGA_CTRL_CLK) begin
    if (w_push) r_fifo[r_wptr] <= {w_wr_addr, disp_bit};
  end

  always_ff @(posedge VGA_CTRL_CLK or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear_req) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Last accepted entry, for dropping back-to-back repeats of the same pixel
  always_ff @(posedge VGA_CTRL_CLK or negedge reset) begin
    if (!reset) begin
      r_last_vld  <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (clear_req) begin
      r_last_vld  <= 1'b0;
    end else if (w_push) begin
      r_last_vld  <= 1'b1;
      r_last_addr <= w_wr_addr;
      r_last_data <= disp_bit;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sweep
  // ---------------------------------------------------------------------------
  always_ff @(posedge VGA_CTRL_CLK or negedge reset) begin
    if (!reset) begin
      r_clr_busy <= 1'b0;
      r_clr_cnt  <= '0;
    end else if (clear_req) begin
      r_clr_busy <= 1'b1;
      r_clr_cnt  <= '0;
    end else if (w_sel == ARB_CLEAR) begin
      if (r_clr_cnt == LAST_ADDR) begin
        r_clr_busy <= 1'b0;
        r_clr_cnt  <= '0;
      end else begin
        r_clr_cnt  <= r_clr_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port and scan colour
  // ---------------------------------------------------------------------------
  always_ff @(posedge VGA_CTRL_CLK or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      unique case (w_sel)
        ARB_READ: begin
          r_mem_addr <= w_disp_addr;
          r_mem_we   <= 1'b0;
        end
        ARB_CLEAR: begin
          r_mem_addr  <= r_clr_cnt;
          r_mem_wdata <= 2'b00;
          r_mem_we    <= 1'b1;
        end
        ARB_WRITE: begin
          r_mem_addr  <= w_head[20:2];
          r_mem_wdata <= w_head[1:0];
          r_mem_we    <= 1'b1;
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  // r_rd_vis tracks the scan position alongside the read address so an
  // off-screen position yields background with the same two-cycle latency.
  always_ff @(posedge VGA_CTRL_CLK or negedge reset) begin
    if (!reset) begin
      r_rd_vis <= 1'b0;
      r_pix    <= 2'b00;
    end else begin
      r_rd_vis <= w_disp_vis;
      r_pix    <= r_rd_vis ? mem_rdata : 2'b00;
    end
  end

  always_ff @(posedge VGA_CTRL_CLK or negedge reset) begin
    if (!reset) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign pixel_color = r_pix;
  assign fifo_full   = w_full;
  assign clear_busy  = r_clr_busy;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_pixel_write_sink.sv
// tb_pixel_write_sink
//   Directed bench: one instance at the default 640x480 geometry and a small
//   20x6 instance so a complete clear sweep stays short.
module tb_pixel_write_sink;

  logic        clk;
  logic        rst_n;

  // Main instance (640x480)
  logic [9:0]  wx;
  logic [8:0]  wy;
  logic        wen;
  logic [1:0]  dbit;
  logic        creq;
  logic [9:0]  dx;
  logic [8:0]  dy;
  logic [18:0] m_addr;
  logic [1:0]  m_wdata;
  logic        m_we;
  logic [1:0]  m_rdata;
  logic [1:0]  pix;
  logic        full;
  logic        busy;
  logic [15:0] drop;

  // Small instance (20x6)
  logic [9:0]  s_wx;
  logic [8:0]  s_wy;
  logic        s_wen;
  logic [1:0]  s_dbit;
  logic        s_creq;
  logic [9:0]  s_dx;
  logic [8:0]  s_dy;
  logic [18:0] s_addr;
  logic [1:0]  s_wdata;
  logic        s_we;
  logic [1:0]  s_rdata;
  logic [1:0]  s_pix;
  logic        s_full;
  logic        s_busy;
  logic [15:0] s_drop;

  int n_total;
  int n_bad;

  // Memory model: address 641 holds 01, every other address reads 11
  assign m_rdata = (m_addr == 19'd641) ? 2'b01 : 2'b11;
  assign s_rdata = 2'b11;

  pixel_write_sink u_dut (
    .VGA_CTRL_CLK   (clk),
    .reset          (rst_n),
    .write_xCoord   (wx),
    .write_yCoord   (wy),
    .w_en           (wen),
    .disp_bit       (dbit),
    .clear_req      (creq),
    .display_xCoord (dx),
    .display_yCoord (dy),
    .mem_addr       (m_addr),
    .mem_wdata      (m_wdata),
    .mem_we         (m_we),
    .mem_rdata      (m_rdata),
    .pixel_color    (pix),
    .fifo_full      (full),
    .clear_busy     (busy),
    .drop_count     (drop)
  );

  pixel_write_sink #(
    .FIFO_DEPTH (8),
    .vga_width  (20),
    .vga_height (6)
  ) u_small (
    .VGA_CTRL_CLK   (clk),
    .reset          (rst_n),
    .write_xCoord   (s_wx),
    .write_yCoord   (s_wy),
    .w_en           (s_wen),
    .disp_bit       (s_dbit),
    .clear_req      (s_creq),
    .display_xCoord (s_dx),
    .display_yCoord (s_dy),
    .mem_addr       (s_addr),
    .mem_wdata      (s_wdata),
    .mem_we         (s_we),
    .mem_rdata      (s_rdata),
    .pixel_color    (s_pix),
    .fifo_full      (s_full),
    .clear_busy     (s_busy),
    .drop_count     (s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          wr_cnt;
  logic [18:0] last_a;
  logic [18:0] la[$];
  logic [1:0]  ld[$];
  int          seq_err;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    wx = '0; wy = '0; wen = 1'b0; dbit = '0; creq = 1'b0;
    dx = '0; dy = 9'd480;
    s_wx = '0; s_wy = '0; s_wen = 1'b0; s_dbit = '0; s_creq = 1'b0;
    s_dx = '0; s_dy = 9'd6;

    // Reset state
    tick();
    tick();
    check("rst_we", 32'(m_we), 32'd0);
    check("rst_addr", 32'(m_addr), 32'd0);
    check("rst_wdata", 32'(m_wdata), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;

    // Single write during blanking: (5,2) -> 2*640+5 = 1285
    wx = 10'd5; wy = 9'd2; dbit = 2'b01; wen = 1'b1;
    tick();
    wen = 1'b0;
    tick();
    check("wr1_we", 32'(m_we), 32'd1);
    check("wr1_addr", 32'(m_addr), 32'd1285);
    check("wr1_data", 32'(m_wdata), 32'd1);
    tick();
    check("wr1_we_off", 32'(m_we), 32'd0);

    // Same pixel three cycles in a row: one write to 10*640+10 = 6410
    wx = 10'd10; wy = 9'd10; dbit = 2'b10; wen = 1'b1;
    wr_cnt = 0;
    last_a = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) wen = 1'b0;
      tick();
      if (m_we) begin
        wr_cnt++;
        last_a = m_addr;
      end
    end
    check("dedup_cnt", 32'(wr_cnt), 32'd1);
    check("dedup_addr", 32'(last_a), 32'd6410);
    check("dedup_drop", 32'(drop), 32'd0);

    // Out-of-range requests
    wr_cnt = 0;
    wx = 10'd640; wy = 9'd0; dbit = 2'b01; wen = 1'b1;
    tick();
    if (m_we) wr_cnt++;
    wx = 10'd0; wy = 9'd480;
    tick();
    if (m_we) wr_cnt++;
    wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_we) wr_cnt++;
    end
    check("oor_writes", 32'(wr_cnt), 32'd0);
    check("oor_drop", 32'(drop), 32'd2);

    // 12 writes during active scan: 8 queued, 4 dropped, drained at blanking
    dy = 9'd0;
    wr_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      dx = 10'(i);
      wx = 10'(100 + i); wy = 9'd3; dbit = 2'b01; wen = 1'b1;
      tick();
      if (m_we) wr_cnt++;
    end
    wen = 1'b0;
    dx = 10'd12;
    tick();
    if (m_we) wr_cnt++;
    check("scan_no_write", 32'(wr_cnt), 32'd0);
    check("scan_full", 32'(full), 32'd1);
    check("scan_drop", 32'(drop), 32'd6);
    dy = 9'd480;
    la.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_we) la.push_back(m_addr);
    end
    check("drain_cnt", 32'(la.size()), 32'd8);
    for (int i = 0; i < 8 && i < la.size(); i++) begin
      check($sformatf("drain_addr%0d", i), 32'(la[i]), 32'(2020 + i));
    end
    check("drain_full", 32'(full), 32'd0);

    // Full queue with a pop in the same cycle still accepts
    dy = 9'd0;
    for (int i = 0; i < 8; i++) begin
      wx = 10'(200 + i); wy = 9'd4; dbit = 2'b10; wen = 1'b1;
      tick();
    end
    check("pp_full", 32'(full), 32'd1);
    dy = 9'd480;
    wx = 10'd208;
    tick();
    wen = 1'b0;
    check("pp_drop", 32'(drop), 32'd6);
    check("pp_full_kept", 32'(full), 32'd1);
    wr_cnt = 0;
    last_a = '0;
    if (m_we) begin
      wr_cnt++;
      last_a = m_addr;
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_we) begin
        wr_cnt++;
        last_a = m_addr;
      end
    end
    check("pp_cnt", 32'(wr_cnt), 32'd9);
    check("pp_last", 32'(last_a), 32'd2768);

    // Scan read: (1,1) -> address 641, colour two cycles later
    dx = 10'd1; dy = 9'd1;
    tick();
    check("rd_addr", 32'(m_addr), 32'd641);
    check("rd_we", 32'(m_we), 32'd0);
    dy = 9'd480;
    tick();
    check("rd_pix641", 32'(pix), 32'd1);
    dx = 10'd2; dy = 9'd0;
    tick();
    dy = 9'd480;
    tick();
    check("rd_pix2", 32'(pix), 32'd3);
    dx = 10'd640; dy = 9'd0;
    tick();
    dy = 9'd480;
    tick();
    check("rd_pix_oor", 32'(pix), 32'd0);
    dx = 10'd0;

    // Small instance: flush on clear_req, restart, write held back until sweep ends
    s_dx = 10'd0; s_dy = 9'd0;
    s_wx = 10'd1; s_wy = 9'd0; s_dbit = 2'b01; s_wen = 1'b1;
    tick();
    s_wx = 10'd2;
    tick();
    s_wen = 1'b0;
    s_dy = 9'd6;
    s_creq = 1'b1;
    tick();
    s_creq = 1'b0;
    check("sclr_busy", 32'(s_busy), 32'd1);
    check("sclr_flush_we", 32'(s_we), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    s_creq = 1'b1;
    tick();
    s_creq = 1'b0;
    s_wx = 10'd3; s_wy = 9'd1; s_dbit = 2'b10; s_wen = 1'b1;
    tick();
    s_wen = 1'b0;
    la.delete();
    ld.delete();
    if (s_we) begin
      la.push_back(s_addr);
      ld.push_back(s_wdata);
    end
    for (int i = 0; i < 300; i++) begin
      tick();
      if (s_we) begin
        la.push_back(s_addr);
        ld.push_back(s_wdata);
      end
    end
    check("sclr_count", 32'(la.size()), 32'd121);
    seq_err = 0;
    for (int i = 0; i < 120 && i < la.size(); i++) begin
      if (la[i] != 19'(i) || ld[i] != 2'b00) seq_err++;
    end
    check("sclr_seq_err", 32'(seq_err), 32'd0);
    if (la.size() > 120) begin
      check("sclr_tail_addr", 32'(la[120]), 32'd23);
      check("sclr_tail_data", 32'(ld[120]), 32'd2);
    end
    check("sclr_busy_end", 32'(s_busy), 32'd0);

    // Main instance: clear in blanking, then reset mid-sweep
    creq = 1'b1;
    tick();
    creq = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("mclr_busy", 32'(busy), 32'd1);
    check("mclr_we", 32'(m_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_we", 32'(m_we), 32'd0);
    check("arst_addr", 32'(m_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_we || busy) wr_cnt++;
    end
    check("arst_no_resume", 32'(wr_cnt), 32'd0);

    // drop_count saturation with out-of-range requests
    wx = 10'd700; wy = 9'd0; wen = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    wen = 1'b0;
    check("drop_sat", 32'(drop), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_write_sink.md
PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, write-queue entries (power of two, 4..32).
REQ-002 Parameter vga_width, default 640, visible columns.
REQ-003 Parameter vga_height, default 480, visible rows.
REQ-004 VGA_CTRL_CLK  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 write_xCoord  in  10  trace pixel column from the trace generator.
REQ-007 write_yCoord  in  9  trace pixel row.
REQ-008 w_en  in  1  write request qualifier, one pixel per high cycle.
REQ-009 disp_bit  in  2  pixel colour code (00 background, 01 trace 1, 10 trace 2).
REQ-010 clear_req  in  1  one-cycle pulse, start full-frame clear.
REQ-011 display_xCoord  in  10  scan column from VGA controller.
REQ-012 display_yCoord  in  9  scan row from VGA controller.
REQ-013 mem_addr  out  19  single-port pixel memory address, registered.
REQ-014 mem_wdata  out  2  memory write data, registered.
REQ-015 mem_we  out  1  memory write strobe, registered.
REQ-016 mem_rdata  in  2  memory read data, valid one cycle after a read address.
REQ-017 pixel_color  out  2  colour for the current scan pixel, registered.
REQ-018 fifo_full  out  1  write queue full.
REQ-019 clear_busy  out  1  clear sweep in progress.
REQ-020 drop_count  out  16  saturating count of discarded write requests.

Function
REQ-021 Address SHALL be y*vga_width + x, 19 bits, computed by shift-add (y<<9 + y<<7 + x at 640), no multiplier.
REQ-022 Write request accepted only when w_en=1, x<vga_width, y<vga_height; out-of-range requests discarded and counted.
REQ-023 Dedup: request whose {addr,disp_bit} equals the last accepted entry SHALL be discarded silently (not counted); last-entry register invalidated by reset and clear_req.
REQ-024 Accepted entries SHALL enter a FIFO_DEPTH-entry queue of {addr[18:0], data[1:0]}, in order.
REQ-025 Queue full with no pop in the same cycle: request discarded, drop_count +1; full with simultaneous pop: request accepted.
REQ-026 drop_count SHALL saturate at 16'hFFFF.
REQ-027 Port arbiter, per cycle, strict priority: (a) READ when display_xCoord<vga_width and display_yCoord<vga_height; (b) CLEAR when clear_busy; (c) WRITE when queue non-empty; else IDLE (mem_we=0, mem_addr held).
REQ-028 READ: mem_addr=display address, mem_we=0; pixel_color=mem_rdata two cycles after the display coordinates are presented.
REQ-029 pixel_color SHALL be 2'b00 for any scan coordinate outside the visible area, with the same 2-cycle alignment.
REQ-030 CLEAR: mem_we=1, mem_wdata=0, mem_addr=clear counter; counter +1 per CLEAR cycle; clear_busy falls the cycle after address vga_width*vga_height-1 is written.
REQ-031 clear_req while clear_busy SHALL restart the sweep at address 0.
REQ-032 clear_req SHALL flush the queue (entries discarded, not counted); writes accepted in later cycles queue normally and drain only after the sweep ends.
REQ-033 WRITE: pop head, mem_we=1, mem_addr/mem_wdata from entry; pop and push in one cycle permitted.
REQ-034 fifo_full SHALL be combinational from registered occupancy, high at occupancy FIFO_DEPTH.

Reset
REQ-035 On reset low: queue empty, fifo_full=0, clear_busy=0, clear counter=0, dedup register invalid, drop_count=0, mem_we=0, mem_addr=0, mem_wdata=0, pixel_color=0.
REQ-036 Reset asserted mid-clear SHALL abort the sweep; no clear resumes after release.
REQ-037 First cycle after reset release SHALL follow REQ-027 normally.

Verification
REQ-038 Blanking (display_y=480), write (x=5,y=2,bit=01) -> one cycle later mem_we=1, mem_addr=1285, mem_wdata=01.
REQ-039 Active scan (display 0..639), 12 distinct in-range writes -> 8 queued, fifo_full=1, drop_count=4, mem_we=0 until blanking, then 8 writes in order.
REQ-040 Same pixel (x=10,y=10,bit=10) on 3 consecutive cycles in blanking -> exactly one memory write, drop_count unchanged.
REQ-041 Write x=640 or y=480 -> no queue entry, drop_count +1.
REQ-042 clear_req in blanking, scan held in blanking -> 307200 consecutive zero writes at addresses 0..307199, clear_busy low the cycle after.
REQ-043 Memory preloaded addr 641=01, display (1,1) presented -> pixel_color=01 exactly two cycles later; reset low mid-clear -> clear_busy=0, mem_we=0 immediately.
